// File: rtl/ysyx_clint_pkg.sv
// Shared bus constants for the core-local timer: RTC register addresses,
// AXI response encodings and the read-address decode result.
package ysyx_clint_pkg;

    localparam logic [31:0] YSYX_BUS_RTC_ADDR    = 32'h0200_0048;
    localparam logic [31:0] YSYX_BUS_RTC_ADDR_UP = 32'h0200_004C;

    localparam int AXI_ID_W = 4;
    localparam int MTIME_W  = 64;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_SLVERR = 2'b10
    } axiResp_e;

    typedef enum logic [1:0] {
        RTC_SEL_LO,
        RTC_SEL_HI,
        RTC_SEL_NONE
    } rtcSel_e;

endpackage

// File: rtl/ysyx_clint_if.sv
// AXI4-style read/write channel bundle between the arbiter (master) and the
// CLINT timer slave.
interface ysyx_clint_if
    import ysyx_clint_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          arburst;
    logic [2:0]          arsize;
    logic [7:0]          arlen;
    logic [AXI_ID_W-1:0] arid;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready_o;
    logic [AXI_ID_W-1:0] rid;
    logic                rlast_o;
    logic [DATA_W-1:0]   rdata_o;
    logic [1:0]          rresp_o;
    logic                rvalid_o;
    logic                rready;

    logic [1:0]          awburst;
    logic [2:0]          awsize;
    logic [7:0]          awlen;
    logic [AXI_ID_W-1:0] awid;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready_o;
    logic                wlast;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready_o;
    logic [AXI_ID_W-1:0] bid;
    logic [1:0]          bresp_o;
    logic                bvalid_o;
    logic                bready;

    modport slave (
        input  arburst, arsize, arlen, arid, araddr, arvalid, rready,
        input  awburst, awsize, awlen, awid, awaddr, awvalid,
        input  wlast, wdata, wstrb, wvalid, bready,
        output arready_o, rid, rlast_o, rdata_o, rresp_o, rvalid_o,
        output awready_o, wready_o, bid, bresp_o, bvalid_o
    );

    modport master (
        output arburst, arsize, arlen, arid, araddr, arvalid, rready,
        output awburst, awsize, awlen, awid, awaddr, awvalid,
        output wlast, wdata, wstrb, wvalid, bready,
        input  arready_o, rid, rlast_o, rdata_o, rresp_o, rvalid_o,
        input  awready_o, wready_o, bid, bresp_o, bvalid_o
    );

endinterface

// File: rtl/ysyx_clint.sv
// Core-local timer: free-running 64-bit mtime readable as two 32-bit words;
// the write channel only exists to answer every write with SLVERR.
module ysyx_clint
    import ysyx_clint_pkg::*;
#(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter logic [ADDR_W-1:0]   RTC_ADDR    = ADDR_W'(YSYX_BUS_RTC_ADDR),
    parameter logic [ADDR_W-1:0]   RTC_ADDR_UP = ADDR_W'(YSYX_BUS_RTC_ADDR_UP),
    parameter logic [MTIME_W-1:0]  MTIME_RST   = '0
) (
    input  logic          clk,
    input  logic          rst,
    ysyx_clint_if.slave   bus
);

    logic [MTIME_W-1:0]  mtime_q;

    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    axiResp_e            rresp_q,  rresp_d;
    logic [AXI_ID_W-1:0] rid_q,    rid_d;

    logic                awSeen_q, awSeen_d;
    logic                wSeen_q,  wSeen_d;
    logic                bvalid_q, bvalid_d;
    axiResp_e            bresp_q,  bresp_d;
    logic [AXI_ID_W-1:0] bid_q,    bid_d;

    logic    arHs, awHs, wHs;
    rtcSel_e rdSel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q <= MTIME_RST;
        end else begin
            mtime_q <= mtime_q + 1'b1;
        end
    end

    assign arHs = bus.arvalid & ~rvalid_q;
    assign awHs = bus.awvalid & ~awSeen_q & ~bvalid_q;
    assign wHs  = bus.wvalid  & ~wSeen_q  & ~bvalid_q;

    always_comb begin
        rdSel = RTC_SEL_NONE;
        if (bus.araddr == RTC_ADDR) begin
            rdSel = RTC_SEL_LO;
        end else if (bus.araddr == RTC_ADDR_UP) begin
            rdSel = RTC_SEL_HI;
        end
    end

    // A read samples mtime as it stands during the handshake cycle and the
    // response is frozen until the master takes it.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rid_d    = rid_q;
        if (rvalid_q & bus.rready) begin
            rvalid_d = 1'b0;
        end
        if (arHs) begin
            rvalid_d = 1'b1;
            rid_d    = bus.arid;
            unique case (rdSel)
                RTC_SEL_LO: begin
                    rdata_d = DATA_W'(mtime_q[31:0]);
                    rresp_d = AXI_RESP_OKAY;
                end
                RTC_SEL_HI: begin
                    rdata_d = DATA_W'(mtime_q[63:32]);
                    rresp_d = AXI_RESP_OKAY;
                end
                default: begin
                    rdata_d = '0;
                    rresp_d = AXI_RESP_SLVERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= AXI_RESP_OKAY;
            rid_q    <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rid_q    <= rid_d;
        end
    end

    // AW and W may arrive in any order; the response is raised one edge after
    // both have been seen, and nothing more is accepted until it is taken.
    always_comb begin
        awSeen_d = awSeen_q | awHs;
        wSeen_d  = wSeen_q | wHs;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        bid_d    = bid_q;
        if (awHs) begin
            bid_d = bus.awid;
        end
        if (awSeen_q & wSeen_q) begin
            awSeen_d = 1'b0;
            wSeen_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = AXI_RESP_SLVERR;
        end
        if (bvalid_q & bus.bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awSeen_q <= 1'b0;
            wSeen_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= AXI_RESP_OKAY;
            bid_q    <= '0;
        end else begin
            awSeen_q <= awSeen_d;
            wSeen_q  <= wSeen_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            bid_q    <= bid_d;
        end
    end

    assign bus.arready_o = ~rvalid_q;
    assign bus.rvalid_o  = rvalid_q;
    assign bus.rlast_o   = rvalid_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.rresp_o   = rresp_q;
    assign bus.rid       = rid_q;

    assign bus.awready_o = ~awSeen_q & ~bvalid_q;
    assign bus.wready_o  = ~wSeen_q & ~bvalid_q;
    assign bus.bvalid_o  = bvalid_q;
    assign bus.bresp_o   = bresp_q;
    assign bus.bid       = bid_q;

    logic unusedInputs;
    assign unusedInputs = ^{bus.arburst, bus.arsize, bus.arlen,
                            bus.awburst, bus.awsize, bus.awlen, bus.awaddr,
                            bus.wlast, bus.wdata, bus.wstrb};

endmodule

// File: tb/tb_ysyx_clint.sv
// Randomised bench for ysyx_clint: a second instance preloaded just below a
// 32-bit boundary shares all inputs so every read also checks the wrap.
module tb_ysyx_clint;
    import ysyx_clint_pkg::*;

    localparam logic [63:0] WRAP_BASE = 64'h0000_0000_FFFF_FFC0;
    localparam logic [31:0] LO_ADDR   = YSYX_BUS_RTC_ADDR;
    localparam logic [31:0] HI_ADDR   = YSYX_BUS_RTC_ADDR_UP;

    logic clk = 1'b0;
    logic rst = 1'b1;

    longint unsigned cycle    = 0;
    longint unsigned relCycle = 0;
    int tests    = 0;
    int failures = 0;

    ysyx_clint_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ysyx_clint_if #(.ADDR_W(32), .DATA_W(32)) busWrap ();

    ysyx_clint dut (.clk(clk), .rst(rst), .bus(bus));
    ysyx_clint #(.MTIME_RST(WRAP_BASE)) dutWrap (.clk(clk), .rst(rst), .bus(busWrap));

    assign busWrap.arburst = bus.arburst;
    assign busWrap.arsize  = bus.arsize;
    assign busWrap.arlen   = bus.arlen;
    assign busWrap.arid    = bus.arid;
    assign busWrap.araddr  = bus.araddr;
    assign busWrap.arvalid = bus.arvalid;
    assign busWrap.rready  = bus.rready;
    assign busWrap.awburst = bus.awburst;
    assign busWrap.awsize  = bus.awsize;
    assign busWrap.awlen   = bus.awlen;
    assign busWrap.awid    = bus.awid;
    assign busWrap.awaddr  = bus.awaddr;
    assign busWrap.awvalid = bus.awvalid;
    assign busWrap.wlast   = bus.wlast;
    assign busWrap.wdata   = bus.wdata;
    assign busWrap.wstrb   = bus.wstrb;
    assign busWrap.wvalid  = bus.wvalid;
    assign busWrap.bready  = bus.bready;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Read one word; holdCycles extra cycles with rready low before acceptance.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id,
                                 input int holdCycles);
        logic [63:0] t, tw;
        logic [31:0] expData, expWrap;
        logic [1:0]  expResp;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arvalid = 1'b1;
        bus.rready  = (holdCycles == 0);
        checkOutput("arready idle", {63'd0, bus.arready_o}, 64'd1);
        t  = cycle - relCycle;
        tw = WRAP_BASE + t;
        if (addr == LO_ADDR) begin
            expData = t[31:0];  expWrap = tw[31:0];  expResp = 2'b00;
        end else if (addr == HI_ADDR) begin
            expData = t[63:32]; expWrap = tw[63:32]; expResp = 2'b00;
        end else begin
            expData = 32'd0;    expWrap = 32'd0;     expResp = 2'b10;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.arid    = ~id;
        bus.araddr  = $urandom;
        checkOutput("rvalid", {63'd0, bus.rvalid_o}, 64'd1);
        checkOutput("rid", {60'd0, bus.rid}, {60'd0, id});
        checkOutput("rlast", {63'd0, bus.rlast_o}, 64'd1);
        checkOutput("arready busy", {63'd0, bus.arready_o}, 64'd0);
        checkOutput("rdata", {32'd0, bus.rdata_o}, {32'd0, expData});
        checkOutput("rresp", {62'd0, bus.rresp_o}, {62'd0, expResp});
        checkOutput("rdata wrap", {32'd0, busWrap.rdata_o}, {32'd0, expWrap});
        checkOutput("wrap status",
                    {56'd0, busWrap.rvalid_o, busWrap.rid, busWrap.rresp_o, busWrap.arready_o},
                    {56'd0, 1'b1, id, expResp, 1'b0});
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk); #1;
            checkOutput("rvalid hold", {63'd0, bus.rvalid_o}, 64'd1);
            checkOutput("rdata hold", {32'd0, bus.rdata_o}, {32'd0, expData});
            checkOutput("rid hold", {60'd0, bus.rid}, {60'd0, id});
            checkOutput("arready hold", {63'd0, bus.arready_o}, 64'd0);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        checkOutput("rvalid drop", {63'd0, bus.rvalid_o}, 64'd0);
        checkOutput("arready back", {63'd0, bus.arready_o}, 64'd1);
    endtask

    // order: 0 AW first, 1 W first, 2 same cycle. releaseB=0 leaves bvalid pending.
    task automatic applyWrite(input int order, input logic [3:0] id,
                              input int holdB, input bit releaseB);
        @(negedge clk);
        bus.bready = 1'b0;
        checkOutput("awready idle", {63'd0, bus.awready_o}, 64'd1);
        checkOutput("wready idle", {63'd0, bus.wready_o}, 64'd1);
        bus.awid    = id;
        bus.awaddr  = $urandom;
        bus.wdata   = $urandom;
        bus.awvalid = (order != 1);
        bus.wvalid  = (order != 0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.awid    = ~id;
        if (order != 2) begin
            checkOutput("first hs flags",
                        {62'd0, bus.awready_o, bus.wready_o},
                        {62'd0, order == 1, order == 0});
            @(negedge clk);
            bus.awid    = id;
            bus.awvalid = (order == 1);
            bus.wvalid  = (order == 0);
            @(posedge clk); #1;
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            bus.awid    = ~id;
        end
        checkOutput("bvalid early", {63'd0, bus.bvalid_o}, 64'd0);
        checkOutput("both seen", {62'd0, bus.awready_o, bus.wready_o}, 64'd0);
        @(posedge clk); #1;
        checkOutput("bvalid", {63'd0, bus.bvalid_o}, 64'd1);
        checkOutput("bresp", {62'd0, bus.bresp_o}, 64'd2);
        checkOutput("bid", {60'd0, bus.bid}, {60'd0, id});
        checkOutput("wrap bstatus",
                    {56'd0, busWrap.bvalid_o, busWrap.bid, busWrap.bresp_o, busWrap.awready_o},
                    {56'd0, 1'b1, id, 2'b10, 1'b0});
        for (int k = 0; k < holdB; k++) begin
            @(posedge clk); #1;
            checkOutput("bvalid hold", {63'd0, bus.bvalid_o}, 64'd1);
            checkOutput("ready blocked", {62'd0, bus.awready_o, bus.wready_o}, 64'd0);
        end
        if (releaseB) begin
            bus.bready = 1'b1;
            @(posedge clk); #1;
            bus.bready = 1'b0;
            checkOutput("bvalid drop", {63'd0, bus.bvalid_o}, 64'd0);
            checkOutput("write ready back", {62'd0, bus.awready_o, bus.wready_o}, 64'd3);
        end
    endtask

    initial begin
        bus.arburst = 2'b01; bus.arsize = 3'd2; bus.arlen = 8'd0;
        bus.arid = '0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awburst = 2'b01; bus.awsize = 3'd2; bus.awlen = 8'd0;
        bus.awid = '0; bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wlast = 1'b1; bus.wdata = '0; bus.wstrb = 4'hF; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset rvalid/rlast", {62'd0, bus.rvalid_o, bus.rlast_o}, 64'd0);
        checkOutput("reset rdata/rresp/rid",
                    {26'd0, bus.rdata_o, bus.rresp_o, bus.rid}, 64'd0);
        checkOutput("reset b", {57'd0, bus.bvalid_o, bus.bresp_o, bus.bid}, 64'd0);
        checkOutput("reset readies",
                    {61'd0, bus.arready_o, bus.awready_o, bus.wready_o}, 64'd7);

        rst = 1'b0;
        relCycle = cycle;
        repeat (10) @(negedge clk);
        applyStimulus(LO_ADDR, 4'h0, 0);
        applyStimulus(LO_ADDR, 4'h5, 0);
        applyStimulus(HI_ADDR, 4'hA, 3);
        applyStimulus(32'h0200_0040, 4'h2, 0);

        while (cycle - relCycle < 58) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(LO_ADDR, 4'(i), 0);
            applyStimulus(HI_ADDR, 4'(i + 8), 0);
        end

        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case (kind)
                0: applyStimulus(LO_ADDR, 4'($urandom), $urandom_range(0, 3));
                1: applyStimulus(HI_ADDR, 4'($urandom), $urandom_range(0, 3));
                2: applyStimulus(32'h0200_0000 | 32'($urandom_range(0, 15) * 4),
                                 4'($urandom), $urandom_range(0, 2));
                default: applyWrite($urandom_range(0, 2), 4'($urandom),
                                    $urandom_range(0, 2), 1'b1);
            endcase
        end

        applyWrite(1, 4'h3, 2, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst bvalid", {63'd0, bus.bvalid_o}, 64'd0);
        checkOutput("async rst b", {58'd0, bus.bresp_o, bus.bid}, 64'd0);
        checkOutput("async rst readies",
                    {61'd0, bus.arready_o, bus.awready_o, bus.wready_o}, 64'd7);
        @(negedge clk);
        rst = 1'b0;
        relCycle = cycle;
        bus.bready = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(LO_ADDR, 4'h7, 0);
        applyStimulus(HI_ADDR, 4'h8, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
